bp_update_scheduler: RTL and testbench

- Sequences all writes into the branch predictor's BTB/tag table and BHT through a single registered write port.
- Runs a one-entry-per-cycle clear sweep after reset and on flush.
- Buffers ID-stage tag/target updates and EX-stage BHT outcome updates in two small FIFOs.
- Arbitrates the FIFOs round-robin and stalls the pipeline while a sweep is in progress.

---
 rtl/bp_update_scheduler_if.sv | 38 +++
 rtl/bp_update_scheduler.sv | 185 ++++++++++++++++++
 tb/tb_bp_update_scheduler.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bp_update_scheduler_if.sv
// Pipeline-facing bundle of the predictor update scheduler: the ID-stage
// tag/target request, the EX-stage BHT request, the registered table write
// port and the sweep-in-progress stall.
interface bp_update_scheduler_if #(
   parameter int IDX_BITS = 8,
   parameter int WORD     = 16
);
   logic                     id_valid;
   logic                     id_ready;
   logic [WORD-1:0]          id_pc;
   logic [WORD-1:0]          id_target;
   logic                     ex_valid;
   logic                     ex_ready;
   logic [WORD-1:0]          ex_pc;
   logic                     ex_correct;
   logic                     wr_valid;
   logic [1:0]               wr_kind;
   logic [IDX_BITS-1:0]      wr_idx;
   logic [WORD-IDX_BITS-1:0] wr_tag;
   logic [WORD-1:0]          wr_target;
   logic [1:0]               wr_bht;
   logic                     wr_correct;
   logic                     busy;

   // Pipeline side: issues requests, observes the table write port.
   modport master (
      output id_valid, id_pc, id_target, ex_valid, ex_pc, ex_correct,
      input  id_ready, ex_ready, wr_valid, wr_kind, wr_idx, wr_tag,
             wr_target, wr_bht, wr_correct, busy
   );

   // Scheduler side.
   modport slave (
      input  id_valid, id_pc, id_target, ex_valid, ex_pc, ex_correct,
      output id_ready, ex_ready, wr_valid, wr_kind, wr_idx, wr_tag,
             wr_target, wr_bht, wr_correct, busy
   );
endinterface

// File: rtl/bp_update_scheduler.sv
// Branch predictor update scheduler. Funnels every BTB/tag and BHT write
// through one registered write port: a clear sweep after reset or flush, then
// round-robin draining of the ID (tag/target) and EX (BHT outcome) FIFOs.
module bp_update_scheduler #(
   parameter int          IDX_BITS   = 8,
   parameter int          WORD       = 16,
   parameter int          FIFO_DEPTH = 4,
   parameter int unsigned CLEAR_TAG  = 1,
   parameter logic [1:0]  CLEAR_BHT  = 2'd3
) (
   input logic                   clk,
   input logic                   reset_n,
   input logic                   flush_req,
   bp_update_scheduler_if.slave  bus
);
   localparam int TAG_W = WORD - IDX_BITS;
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [IDX_BITS-1:0] CNT_MAX      = '1;
   localparam logic [TAG_W-1:0]    CLR_TAG_VAL  = TAG_W'(CLEAR_TAG);
   localparam logic [CNT_W-1:0]    FIFO_FULL    = CNT_W'(FIFO_DEPTH);
   localparam logic [1:0]          KIND_CLEAR   = 2'd0;
   localparam logic [1:0]          KIND_TAG     = 2'd1;
   localparam logic [1:0]          KIND_BHT     = 2'd2;

   typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;
   typedef enum logic {RR_TAG = 1'b0, RR_EX = 1'b1} rr_t;

   state_t              r_state, w_state_nxt;
   logic [IDX_BITS-1:0] r_cnt, w_cnt_nxt;
   rr_t                 r_rr;

   // Request FIFOs: storage plus binary pointers and an occupancy count.
   logic [WORD-1:0]  r_tag_pc  [FIFO_DEPTH];
   logic [WORD-1:0]  r_tag_tgt [FIFO_DEPTH];
   logic [WORD-1:0]  r_bht_pc  [FIFO_DEPTH];
   logic             r_bht_cor [FIFO_DEPTH];
   logic [PTR_W-1:0] r_tag_wr, r_tag_rd, r_bht_wr, r_bht_rd;
   logic [CNT_W-1:0] r_tag_cnt, r_bht_cnt;

   logic                r_wr_valid;
   logic [1:0]          r_wr_kind;
   logic [IDX_BITS-1:0] r_wr_idx;
   logic [TAG_W-1:0]    r_wr_tag;
   logic [WORD-1:0]     r_wr_target;
   logic [1:0]          r_wr_bht;
   logic                r_wr_correct;

   logic w_run, w_tag_empty, w_bht_empty;
   logic w_tag_push, w_bht_push, w_pop_tag, w_pop_bht;

   assign w_run       = (r_state == ST_RUN);
   assign w_tag_empty = (r_tag_cnt == '0);
   assign w_bht_empty = (r_bht_cnt == '0);

   // Fullness is the pre-pop count, so a full FIFO never accepts.
   assign bus.id_ready = w_run && (r_tag_cnt != FIFO_FULL);
   assign bus.ex_ready = w_run && (r_bht_cnt != FIFO_FULL);
   assign bus.busy     = (r_state == ST_CLEAR);

   assign w_tag_push = bus.id_valid && bus.id_ready && !flush_req;
   assign w_bht_push = bus.ex_valid && bus.ex_ready && !flush_req;
   assign w_pop_tag  = w_run && !flush_req && !w_tag_empty && (w_bht_empty || r_rr == RR_TAG);
   assign w_pop_bht  = w_run && !flush_req && !w_bht_empty && (w_tag_empty || r_rr == RR_EX);

   // State register for the sweep/run controller.
   always_ff @(posedge clk) begin
      // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
      if (!reset_n) begin
         r_state <= ST_CLEAR;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Next state: flush restarts the sweep; the sweep ends after the last index.
   always_comb begin
      // NOTE: defaults first so every path assigns and no latch is inferred.
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      if (flush_req) begin
         w_state_nxt = ST_CLEAR;
         w_cnt_nxt   = '0;
      end else if (r_state == ST_CLEAR) begin
         if (r_cnt == CNT_MAX) begin
            w_state_nxt = ST_RUN;
            w_cnt_nxt   = '0;
         end else begin
            w_cnt_nxt = r_cnt + 1'b1;
         end
      end
   end

   // Tag FIFO pointers and occupancy; flush drops all queued entries.
   always_ff @(posedge clk) begin
      if (!reset_n || flush_req) begin
         r_tag_wr  <= '0;
         r_tag_rd  <= '0;
         r_tag_cnt <= '0;
      end else begin
         if (w_tag_push) r_tag_wr <= r_tag_wr + 1'b1;
         if (w_pop_tag)  r_tag_rd <= r_tag_rd + 1'b1;
         r_tag_cnt <= r_tag_cnt + CNT_W'(w_tag_push) - CNT_W'(w_pop_tag);
      end
   end

   // BHT FIFO pointers and occupancy.
   always_ff @(posedge clk) begin
      if (!reset_n || flush_req) begin
         r_bht_wr  <= '0;
         r_bht_rd  <= '0;
         r_bht_cnt <= '0;
      end else begin
         if (w_bht_push) r_bht_wr <= r_bht_wr + 1'b1;
         if (w_pop_bht)  r_bht_rd <= r_bht_rd + 1'b1;
         r_bht_cnt <= r_bht_cnt + CNT_W'(w_bht_push) - CNT_W'(w_pop_bht);
      end
   end

   // FIFO payload storage, written on accept.
   always_ff @(posedge clk) begin
      // NOTE: payload arrays carry no reset; the counts alone decide what is valid.
      if (w_tag_push) begin
         r_tag_pc[r_tag_wr]  <= bus.id_pc;
         r_tag_tgt[r_tag_wr] <= bus.id_target;
      end
      if (w_bht_push) begin
         r_bht_pc[r_bht_wr]  <= bus.ex_pc;
         r_bht_cor[r_bht_wr] <= bus.ex_correct;
      end
   end

   // Round-robin pointer: after any pop the other side gets priority.
   always_ff @(posedge clk) begin
      if (!reset_n)       r_rr <= RR_EX;
      else if (w_pop_tag) r_rr <= RR_EX;
      else if (w_pop_bht) r_rr <= RR_TAG;
   end

   // Registered table write port: clear sweep, tag pop, BHT pop or idle.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_wr_valid   <= 1'b0;
         r_wr_kind    <= '0;
         r_wr_idx     <= '0;
         r_wr_tag     <= '0;
         r_wr_target  <= '0;
         r_wr_bht     <= '0;
         r_wr_correct <= 1'b0;
      end else if (flush_req) begin
         r_wr_valid <= 1'b0;
      end else if (r_state == ST_CLEAR) begin
         r_wr_valid   <= 1'b1;
         r_wr_kind    <= KIND_CLEAR;
         r_wr_idx     <= r_cnt;
         r_wr_tag     <= CLR_TAG_VAL;
         r_wr_target  <= '0;
         r_wr_bht     <= CLEAR_BHT;
         r_wr_correct <= 1'b0;
      end else if (w_pop_tag) begin
         r_wr_valid  <= 1'b1;
         r_wr_kind   <= KIND_TAG;
         r_wr_idx    <= r_tag_pc[r_tag_rd][IDX_BITS-1:0];
         r_wr_tag    <= r_tag_pc[r_tag_rd][WORD-1:IDX_BITS];
         r_wr_target <= r_tag_tgt[r_tag_rd];
      end else if (w_pop_bht) begin
         r_wr_valid   <= 1'b1;
         r_wr_kind    <= KIND_BHT;
         r_wr_idx     <= r_bht_pc[r_bht_rd][IDX_BITS-1:0];
         r_wr_correct <= r_bht_cor[r_bht_rd];
      end else begin
         r_wr_valid <= 1'b0;
      end
   end

   assign bus.wr_valid   = r_wr_valid;
   assign bus.wr_kind    = r_wr_kind;
   assign bus.wr_idx     = r_wr_idx;
   assign bus.wr_tag     = r_wr_tag;
   assign bus.wr_target  = r_wr_target;
   assign bus.wr_bht     = r_wr_bht;
   assign bus.wr_correct = r_wr_correct;
endmodule

// File: tb/tb_bp_update_scheduler.sv
// Self-checking bench for bp_update_scheduler: expected writes are queued at
// request acceptance and compared as the write port produces them.
module tb_bp_update_scheduler;
   localparam int IDX_BITS = 8;
   localparam int WORD     = 16;
   localparam int DEPTH    = 4;
   localparam int N_IDX    = 256;

   typedef struct {
      logic [7:0]  idx;
      logic [7:0]  tag;
      logic [15:0] target;
   } tag_exp_t;

   typedef struct {
      logic [7:0] idx;
      logic       correct;
   } bht_exp_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic flush_req = 1'b0;

   bp_update_scheduler_if #(.IDX_BITS(IDX_BITS), .WORD(WORD)) bus ();

   bp_update_scheduler #(
      .IDX_BITS(IDX_BITS), .WORD(WORD), .FIFO_DEPTH(DEPTH),
      .CLEAR_TAG(1), .CLEAR_BHT(2'd3)
   ) dut (
      .clk(clk), .reset_n(reset_n), .flush_req(flush_req), .bus(bus)
   );

   always #5 clk = ~clk;

   tag_exp_t   q_tag[$];
   bht_exp_t   q_bht[$];
   logic [1:0] kind_log[$];
   bit         log_en = 1'b0;
   int         n_total = 0;
   int         n_bad = 0;
   int         clr_exp = 0;
   int         clr_seen = 0;
   int         tag_occ = 0;
   int         bht_occ = 0;
   tag_exp_t   mon_te;
   bht_exp_t   mon_be;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // Scoreboard monitor, sampling 1 time unit after each rising edge.
   always begin
      @(posedge clk);
      #1;
      if (bus.wr_valid === 1'b1) begin
         if (log_en) kind_log.push_back(bus.wr_kind);
         case (bus.wr_kind)
            2'd0: begin
               check("clr_idx", bus.wr_idx, clr_exp[7:0]);
               check("clr_tag", bus.wr_tag, 1);
               check("clr_bht", bus.wr_bht, 3);
               check("clr_target", bus.wr_target, 0);
               clr_exp++;
               clr_seen++;
            end
            2'd1: begin
               check("tag_q_nonempty", q_tag.size() != 0, 1);
               if (q_tag.size() != 0) begin
                  mon_te = q_tag.pop_front();
                  check("tag_idx", bus.wr_idx, mon_te.idx);
                  check("tag_tag", bus.wr_tag, mon_te.tag);
                  check("tag_target", bus.wr_target, mon_te.target);
                  tag_occ--;
               end
            end
            2'd2: begin
               check("bht_q_nonempty", q_bht.size() != 0, 1);
               if (q_bht.size() != 0) begin
                  mon_be = q_bht.pop_front();
                  check("bht_idx", bus.wr_idx, mon_be.idx);
                  check("bht_correct", bus.wr_correct, mon_be.correct);
                  bht_occ--;
               end
            end
            default: check("wr_kind_legal", bus.wr_kind, 0);
         endcase
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1);
   end

   // Drive one cycle of requests at a falling edge; queue what will be accepted.
   task automatic drive(input bit iv, input logic [15:0] ipc, input logic [15:0] itgt,
                        input bit ev, input logic [15:0] epc, input bit ec,
                        output bit id_acc, output bit ex_acc);
      tag_exp_t te;
      bht_exp_t be;
      bus.id_valid   = iv;
      bus.id_pc      = ipc;
      bus.id_target  = itgt;
      bus.ex_valid   = ev;
      bus.ex_pc      = epc;
      bus.ex_correct = ec;
      id_acc = iv && bus.id_ready && !flush_req;
      ex_acc = ev && bus.ex_ready && !flush_req;
      if (id_acc) begin
         te.idx = ipc[7:0]; te.tag = ipc[15:8]; te.target = itgt;
         q_tag.push_back(te);
         tag_occ++;
      end
      if (ex_acc) begin
         be.idx = epc[7:0]; be.correct = ec;
         q_bht.push_back(be);
         bht_occ++;
      end
   endtask

   task automatic idle();
      bus.id_valid = 1'b0;
      bus.ex_valid = 1'b0;
   endtask

   task automatic forget_pending();
      q_tag.delete();
      q_bht.delete();
      tag_occ  = 0;
      bht_occ  = 0;
      clr_exp  = 0;
      clr_seen = 0;
   endtask

   // Called at the first falling edge of a sweep; follows it to the end.
   task automatic wait_sweep(input string name);
      int n = 0;
      while (bus.busy && n < 1000) begin
         n++;
         @(negedge clk);
      end
      check({name, "_busy_cycles"}, n, N_IDX);
      check({name, "_clear_writes"}, clr_seen, N_IDX);
      @(negedge clk);
      check({name, "_idle_valid"}, bus.wr_valid, 0);
      check({name, "_id_ready"}, bus.id_ready, 1);
      check({name, "_ex_ready"}, bus.ex_ready, 1);
   endtask

   // Flush at the current falling edge with live requests that must be dropped.
   task automatic do_flush(input string name);
      bit ia, ea;
      flush_req = 1'b1;
      drive(1'b1, 16'hBEEF, 16'h0BAD, 1'b1, 16'hCAFE, 1'b1, ia, ea);
      forget_pending();
      @(negedge clk);
      flush_req = 1'b0;
      idle();
      check({name, "_valid_low"}, bus.wr_valid, 0);
      check({name, "_busy"}, bus.busy, 1);
   endtask

   task automatic wait_clear_idx(input int idx, input string name);
      int n = 0;
      while (!(bus.wr_valid && bus.wr_kind == 2'd0 && bus.wr_idx == idx[7:0]) && n < 1000) begin
         n++;
         @(negedge clk);
      end
      check({name, "_reached"}, bus.wr_idx, idx[7:0]);
   endtask

   initial begin
      bit ia, ea;
      int tag_acc, bht_acc, ex_blocked, n;
      logic [15:0] t_pc, t_tgt, b_pc;
      logic        b_cor;

      idle();
      bus.id_pc = '0; bus.id_target = '0; bus.ex_pc = '0; bus.ex_correct = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_wr_valid", bus.wr_valid, 0);
      check("rst_wr_idx", bus.wr_idx, 0);
      check("rst_busy", bus.busy, 1);
      check("rst_id_ready", bus.id_ready, 0);
      check("rst_ex_ready", bus.ex_ready, 0);
      reset_n = 1'b1;
      wait_sweep("power_on");

      // Single tag update, visible one edge after acceptance.
      drive(1'b1, 16'h1234, 16'h0040, 1'b0, 16'h0, 1'b0, ia, ea);
      check("single_accept", ia, 1);
      @(negedge clk);
      idle();
      @(negedge clk);
      check("single_valid", bus.wr_valid, 1);
      check("single_kind", bus.wr_kind, 1);
      check("single_idx", bus.wr_idx, 8'h34);
      check("single_tag", bus.wr_tag, 8'h12);
      check("single_target", bus.wr_target, 16'h0040);
      @(negedge clk);

      // Four of each side together: arbitration alternates starting with BHT.
      kind_log.delete();
      log_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 16'h1100 + 16'(i), 16'h2000 + 16'(i), 1'b1, 16'h3300 + 16'(i), i[0], ia, ea);
         @(negedge clk);
      end
      idle();
      repeat (10) @(negedge clk);
      log_en = 1'b0;
      check("alt_count", kind_log.size(), 8);
      for (int i = 0; i < kind_log.size() && i < 8; i++)
         check($sformatf("alt_kind_%0d", i), kind_log[i], (i % 2 == 0) ? 2 : 1);

      // Sustained traffic on both sides fills the FIFOs; readies follow occupancy.
      tag_acc = 0; bht_acc = 0; ex_blocked = 0; n = 0;
      t_pc = 16'($urandom); t_tgt = 16'($urandom); b_pc = 16'($urandom); b_cor = 1'($urandom);
      while ((tag_acc < 10 || bht_acc < 10) && n < 200) begin
         n++;
         check("fill_id_ready", bus.id_ready, tag_occ < DEPTH);
         check("fill_ex_ready", bus.ex_ready, bht_occ < DEPTH);
         if (bht_acc < 10 && !bus.ex_ready) ex_blocked++;
         drive(tag_acc < 10, t_pc, t_tgt, bht_acc < 10, b_pc, b_cor, ia, ea);
         if (ia) begin tag_acc++; t_pc = 16'($urandom); t_tgt = 16'($urandom); end
         if (ea) begin bht_acc++; b_pc = 16'($urandom); b_cor = 1'($urandom); end
         @(negedge clk);
      end
      idle();
      check("fill_ex_full_seen", ex_blocked != 0, 1);
      repeat (20) @(negedge clk);
      check("fill_tag_drained", q_tag.size(), 0);
      check("fill_bht_drained", q_bht.size(), 0);

      // Flush with queued entries and a same-cycle request: nothing queued survives.
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 16'h4400 + 16'(i), 16'h5500 + 16'(i), 1'b1, 16'h6600 + 16'(i), 1'b1, ia, ea);
         @(negedge clk);
      end
      check("preflush_queued", q_tag.size() + q_bht.size(), 3);
      do_flush("run_flush");

      // Flush again mid-sweep: sweep restarts from index 0.
      wait_clear_idx(100, "sweep_idx100");
      do_flush("sweep_flush");
      wait_sweep("after_sweep_flush");

      // Reset mid-sweep behaves like power-on reset.
      do_flush("pre_reset_flush");
      wait_clear_idx(50, "sweep_idx50");
      reset_n = 1'b0;
      forget_pending();
      @(negedge clk);
      check("midrst_valid", bus.wr_valid, 0);
      check("midrst_idx", bus.wr_idx, 0);
      check("midrst_busy", bus.busy, 1);
      reset_n = 1'b1;
      wait_sweep("after_reset");

      // Arbiter pointer is back to EX after reset: BHT wins the first contention.
      kind_log.delete();
      log_en = 1'b1;
      drive(1'b1, 16'h7788, 16'h99AA, 1'b1, 16'h7789, 1'b0, ia, ea);
      @(negedge clk);
      idle();
      repeat (4) @(negedge clk);
      log_en = 1'b0;
      check("rr_reset_count", kind_log.size(), 2);
      if (kind_log.size() != 0) check("rr_reset_first", kind_log[0], 2);
      check("end_tag_drained", q_tag.size(), 0);
      check("end_bht_drained", q_bht.size(), 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
